// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the two requester ports and the memory-side
// port of mem_arbiter.
//
// Optional feature macro: MEM_ARB_WSTRB_EN
//   defined   : adds per-requester 4-bit byte strobes (wstrb_a/wstrb_b) and
//               widens mem_write to one strobe per byte lane.
//   undefined : no strobes, mem_write is a single bit (full-word writes).
//
// Signals
//   req_a/req_b, we_a/we_b, addr_a/addr_b, wdata_a/wdata_b : requester commands
//   gnt_a/gnt_b       : one-cycle grant pulse (command sampled that cycle)
//   rvalid_a/rvalid_b : one-cycle read-data-valid pulse for the owner
//   rdata             : shared read data, qualified by rvalid_a/rvalid_b
//   busy              : arbiter is not idle
//   mem_read/mem_write/mem_address/mem_data_in : memory command (to memory)
//   mem_data_out      : memory read data (from memory)
//
// Modports
//   slave  : the arbiter side
//   master : the requester/memory environment side
interface mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
`ifdef MEM_ARB_WSTRB_EN
    logic [3:0]        wstrb_a;
    logic [3:0]        wstrb_b;
    logic [3:0]        mem_write;
`else
    logic              mem_write;
`endif
    logic              gnt_a;
    logic              gnt_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
`ifdef MEM_ARB_WSTRB_EN
        input  wstrb_a, wstrb_b,
`endif
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, busy,
        output mem_read, mem_write, mem_address, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
`ifdef MEM_ARB_WSTRB_EN
        output wstrb_a, wstrb_b,
`endif
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, busy,
        input  mem_read, mem_write, mem_address, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester round-robin arbiter in front of a single-port
// 16-word memory. One transaction every three cycles: IDLE (grant and command
// capture), ACCESS (memory strobe), RESP (read data valid to the owner).
//
// Optional feature macro: MEM_ARB_WSTRB_EN (per-byte write strobes).
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-high; aborts any in-flight transaction
//   bus   : mem_arbiter_if.slave -- requester A/B commands, grants, rvalids,
//           shared rdata, busy, and the memory command/data port
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;       // 0: A wins a tie, 1: B wins a tie
    logic              owner_q, owner_d;   // 0: A, 1: B
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_WSTRB_EN
    logic [3:0]        wstrb_q, wstrb_d;
`endif
    logic              grant_s;
    logic              winner_s;           // 0: A, 1: B

    // Arbitration: only in IDLE; a lone requester wins regardless of pointer.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.req_a && bus.req_b) begin
                grant_s  = 1'b1;
                winner_s = ptr_q;
            end else if (bus.req_a) begin
                grant_s  = 1'b1;
                winner_s = 1'b0;
            end else if (bus.req_b) begin
                grant_s  = 1'b1;
                winner_s = 1'b1;
            end else begin
                grant_s  = 1'b0;
                winner_s = 1'b0;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end
    end

    // Next-state logic: ACCESS and RESP each last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = grant_s ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Command capture on grant and read-data capture at the end of ACCESS.
    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_WSTRB_EN
        wstrb_d = wstrb_q;
`endif
        if (grant_s) begin
            // pointer always moves to the requester that did not win
            ptr_d   = ~winner_s;
            owner_d = winner_s;
            we_d    = winner_s ? bus.we_b    : bus.we_a;
            addr_d  = winner_s ? bus.addr_b  : bus.addr_a;
            wdata_d = winner_s ? bus.wdata_b : bus.wdata_a;
`ifdef MEM_ARB_WSTRB_EN
            wstrb_d = winner_s ? bus.wstrb_b : bus.wstrb_a;
`endif
        end else begin
            ptr_d = ptr_q;
        end
        if ((state_q == ST_ACCESS) && !we_q) begin
            rdata_d = bus.mem_data_out;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_WSTRB_EN
            wstrb_q <= 4'b0000;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_WSTRB_EN
            wstrb_q <= wstrb_d;
`endif
        end
    end

    // Outputs decoded from the current state and the captured command.
    always_comb begin
        bus.gnt_a       = grant_s && !winner_s;
        bus.gnt_b       = grant_s && winner_s;
        bus.busy        = (state_q != ST_IDLE);
        bus.mem_read    = (state_q == ST_ACCESS) && !we_q;
`ifdef MEM_ARB_WSTRB_EN
        bus.mem_write   = ((state_q == ST_ACCESS) && we_q) ? wstrb_q : 4'b0000;
`else
        bus.mem_write   = (state_q == ST_ACCESS) && we_q;
`endif
        bus.rvalid_a    = (state_q == ST_RESP) && !we_q && !owner_q;
        bus.rvalid_b    = (state_q == ST_RESP) && !we_q && owner_q;
        bus.mem_address = addr_q;
        bus.mem_data_in = wdata_q;
        bus.rdata       = rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter. A transaction-level
// reference model (grant cycle arithmetic plus a word array) predicts every
// output each cycle; directed scenarios are followed by randomized traffic.
// Build with +define+MEM_ARB_WSTRB_EN to exercise the byte-strobe variant.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment memory: combinational read, clocked write, cleared on reset.
    logic [31:0] tb_mem [16];
    assign bus.mem_data_out = tb_mem[bus.mem_address];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 32'h0;
        end else begin
`ifdef MEM_ARB_WSTRB_EN
            for (int l = 0; l < 4; l++)
                if (bus.mem_write[l]) tb_mem[bus.mem_address][8*l +: 8] <= bus.mem_data_in[8*l +: 8];
`else
            if (bus.mem_write) tb_mem[bus.mem_address] <= bus.mem_data_in;
`endif
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Requester drive values, index 0 = A, 1 = B.
    logic        d_req   [2];
    logic        d_we    [2];
    logic [3:0]  d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [3:0]  d_wstrb [2];

    // Reference model state.
    int          cyc;
    int          g_cyc;
    bit          g_side;
    bit          g_we;
    logic [3:0]  g_addr;
    logic [3:0]  g_strb;
    logic [31:0] g_data;
    bit          ptr_b;
    logic [31:0] exp_rdata;
    logic [31:0] ref_mem [16];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++)
            if (strb[l]) r[8*l +: 8] = new_w[8*l +: 8];
        return r;
    endfunction

    task automatic model_reset();
        cyc       = 0;
        g_cyc     = -100;
        ptr_b     = 1'b0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic apply_drives();
        bus.req_a   = d_req[0];   bus.req_b   = d_req[1];
        bus.we_a    = d_we[0];    bus.we_b    = d_we[1];
        bus.addr_a  = d_addr[0];  bus.addr_b  = d_addr[1];
        bus.wdata_a = d_wdata[0]; bus.wdata_b = d_wdata[1];
`ifdef MEM_ARB_WSTRB_EN
        bus.wstrb_a = d_wstrb[0]; bus.wstrb_b = d_wstrb[1];
`endif
    endtask

    // One clock cycle: drive at the falling edge, then compare every output
    // with what the model expects for this cycle.
    task automatic cycle(output bit got_a, output bit got_b);
        bit          in_access, in_resp, idle, w;
        bit          e_ga, e_gb;
        logic [3:0]  e_mw;
        @(negedge clk);
        apply_drives();
        #1;
        in_access = (cyc == g_cyc + 1);
        in_resp   = (cyc == g_cyc + 2);
        idle      = (cyc >= g_cyc + 3);
        if (in_resp && !g_we) exp_rdata = g_data;
`ifdef MEM_ARB_WSTRB_EN
        e_mw = (in_access && g_we) ? g_strb : 4'b0000;
`else
        e_mw = (in_access && g_we) ? 4'b0001 : 4'b0000;
`endif
        check_val("busy",      32'(bus.busy),      32'(in_access || in_resp));
        check_val("mem_read",  32'(bus.mem_read),  32'(in_access && !g_we));
        check_val("mem_write", 32'(bus.mem_write), 32'(e_mw));
        check_val("rvalid_a",  32'(bus.rvalid_a),  32'(in_resp && !g_we && !g_side));
        check_val("rvalid_b",  32'(bus.rvalid_b),  32'(in_resp && !g_we && g_side));
        check_val("rdata",     bus.rdata,          exp_rdata);
        if (in_access) begin
            check_val("mem_address", 32'(bus.mem_address), 32'(g_addr));
            if (g_we) check_val("mem_data_in", bus.mem_data_in, g_data);
        end
        e_ga = 1'b0;
        e_gb = 1'b0;
        if (idle && (d_req[0] || d_req[1])) begin
            w      = (d_req[0] && d_req[1]) ? ptr_b : d_req[1];
            e_ga   = !w;
            e_gb   = w;
            g_cyc  = cyc;
            g_side = w;
            g_we   = d_we[w];
            g_addr = d_addr[w];
`ifdef MEM_ARB_WSTRB_EN
            g_strb = d_wstrb[w];
`else
            g_strb = 4'hF;
`endif
            if (g_we) begin
                g_data = d_wdata[w];
                ref_mem[g_addr] = merge(ref_mem[g_addr], d_wdata[w], g_strb);
            end else begin
                g_data = ref_mem[g_addr];
            end
            ptr_b = !w;
        end
        check_val("gnt_a", 32'(bus.gnt_a), 32'(e_ga));
        check_val("gnt_b", 32'(bus.gnt_b), 32'(e_gb));
        got_a = bus.gnt_a;
        got_b = bus.gnt_b;
        cyc++;
    endtask

    task automatic clear_drives();
        for (int s = 0; s < 2; s++) begin
            d_req[s] = 1'b0; d_we[s] = 1'b0; d_addr[s] = 4'h0;
            d_wdata[s] = 32'h0; d_wstrb[s] = 4'h0;
        end
    endtask

    // Hold reset over two rising edges, check the reset state, release.
    task automatic do_reset();
        reset = 1'b1;
        clear_drives();
        apply_drives();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_gnt",    32'({bus.gnt_a, bus.gnt_b}),       32'h0);
        check_val("rst_rvalid", 32'({bus.rvalid_a, bus.rvalid_b}), 32'h0);
        check_val("rst_busy",   32'(bus.busy),                     32'h0);
        check_val("rst_mem",    32'({bus.mem_read, bus.mem_write}), 32'h0);
        check_val("rst_rdata",  bus.rdata,                         32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    // Issue one command from side s, hold it until granted, then let the
    // transaction finish.
    task automatic txn(input int s, input bit we, input logic [3:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
        bit ga, gb, got;
        d_we[s] = we; d_addr[s] = addr; d_wdata[s] = data; d_wstrb[s] = strb;
        d_req[s] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cycle(ga, gb);
            got = (s == 0) ? ga : gb;
        end
        if (!got) check_val("txn_timeout", 32'h0, 32'h1);
        d_req[s] = 1'b0;
        repeat (2) cycle(ga, gb);
    endtask

    initial begin
        bit ga, gb;
        int nwin;
        bit wins [8];
        reset = 1'b1;
        clear_drives();
        apply_drives();
        model_reset();

        // write then read back through requester A
        do_reset();
        txn(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
        txn(0, 1'b0, 4'd3, 32'h0, 4'h0);
        check_val("raw_a_addr3", bus.rdata, 32'hDEADBEEF);

        // simultaneous requests alternate A, B, A, B
        do_reset();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 4'd0;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 4'd1;
        nwin = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(ga, gb);
            if (ga || gb) begin
                if (nwin < 8) wins[nwin] = gb;
                nwin++;
            end
        end
        check_val("rr_count", 32'(nwin), 32'd4);
        check_val("rr_win0", 32'(wins[0]), 32'd0);
        check_val("rr_win1", 32'(wins[1]), 32'd1);
        check_val("rr_win2", 32'(wins[2]), 32'd0);
        check_val("rr_win3", 32'(wins[3]), 32'd1);
        clear_drives();

        // B alone, four reads of address 15
        txn(1, 1'b1, 4'd15, 32'hCAFE0015, 4'hF);
        for (int i = 0; i < 4; i++) txn(1, 1'b0, 4'd15, 32'h0, 4'h0);
        check_val("b_read15", bus.rdata, 32'hCAFE0015);

        // address change during ACCESS does not disturb the in-flight read
        txn(0, 1'b1, 4'd2, 32'h22222222, 4'hF);
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 4'd2;
        cycle(ga, gb);
        check_val("hold_gnt", 32'(ga), 32'd1);
        d_req[0] = 1'b0; d_addr[0] = 4'd9; d_we[0] = 1'b1;
        cycle(ga, gb);
        check_val("hold_addr", 32'(bus.mem_address), 32'd2);
        cycle(ga, gb);
        check_val("hold_rdata", bus.rdata, 32'h22222222);
        clear_drives();

`ifdef MEM_ARB_WSTRB_EN
        // partial-lane write merges into the existing word
        txn(0, 1'b1, 4'd5, 32'h11223344, 4'b1111);
        txn(1, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
        txn(0, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000);
        txn(0, 1'b0, 4'd5, 32'h0, 4'h0);
        check_val("wstrb_merge", bus.rdata, 32'h11BB33DD);
`endif

        // reset in the middle of a read aborts it
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 4'd3;
        cycle(ga, gb);
        d_req[0] = 1'b0;
        cycle(ga, gb);
        reset = 1'b1;
        #1;
        check_val("abort_busy",  32'(bus.busy),     32'd0);
        check_val("abort_mread", 32'(bus.mem_read), 32'd0);
        @(posedge clk);
        #1;
        check_val("abort_rvalid", 32'({bus.rvalid_a, bus.rvalid_b}), 32'd0);
        do_reset();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 4'd7;
        cycle(ga, gb);
        check_val("post_rst_gnt_a", 32'(ga), 32'd1);
        d_req[0] = 1'b0;
        repeat (2) cycle(ga, gb);

        // randomized traffic from both requesters
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (!d_req[s]) begin
                    d_we[s]    = 1'($urandom_range(0, 1));
                    d_addr[s]  = 4'($urandom_range(0, 3));
                    d_wdata[s] = $urandom;
                    d_wstrb[s] = 4'($urandom_range(0, 15));
                    d_req[s]   = ($urandom_range(0, 2) != 0);
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req[s] = 1'b0;
                end
            end
            cycle(ga, gb);
            if (ga) begin
                d_req[0] = 1'b0; d_addr[0] = 4'($urandom_range(0, 15)); d_wdata[0] = $urandom;
            end
            if (gb) begin
                d_req[1] = 1'b0; d_addr[1] = 4'($urandom_range(0, 15)); d_wdata[1] = $urandom;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
